// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared types and constants for the mul/div scoreboard controller
// Contents:
//   muldiv_state_e  controller state encoding (IDLE, RUN, WB)
//   MUL_LAT_DEF / DIV_LAT_DEF  default unit latencies
//   muldiv_req_t    issue-side and D-stage fields consumed by the dependency check
package riscv_defines;

    localparam int MUL_LAT_DEF = 3;
    localparam int DIV_LAT_DEF = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } muldiv_state_e;

    typedef struct packed {
        logic       issue_valid;
        logic       issue_is_div;
        logic       issue_divzero;
        logic [4:0] issue_rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       regwrite;
        logic       muldiv;
    } muldiv_req_t;

endpackage

// File: rtl/muldiv_dep_checker.sv
// rtl/muldiv_dep_checker.sv - RAW/WAW/structural conflict compare for the D stage
// Ports:
//   req        issue and D-stage fields
//   accept     an issue is being accepted this cycle
//   busy       controller not idle (registered)
//   pend       in-flight op still owes a register write
//   prd        in-flight op destination register
//   stall_req  stall F/D and flush E
module muldiv_dep_checker
    import riscv_defines::*;
(
    input  muldiv_req_t req,
    input  logic        accept,
    input  logic        busy,
    input  logic        pend,
    input  logic [4:0]  prd,
    output logic        stall_req
);

    logic [4:0] cprd;
    logic       cv;
    logic       unused_fields;

    // The op being accepted this cycle is already a hazard for the instruction in D.
    assign cprd = accept ? req.issue_rd : prd;
    assign cv   = (accept && req.issue_rd != 5'd0) || pend;

    assign stall_req = (cv && req.uses_rs1 && req.rs1 == cprd)
                    || (cv && req.uses_rs2 && req.rs2 == cprd)
                    || (cv && req.regwrite && req.rd == cprd)
                    || (req.muldiv && (busy || accept));

    assign unused_fields = ^{req.issue_valid, req.issue_is_div, req.issue_divzero};

endmodule

// File: rtl/muldiv_scoreboard_ctrl.sv
// rtl/muldiv_scoreboard_ctrl.sv - sequencer/scoreboard for the multi-cycle mul/div unit
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   issue_*_e, flush_e, kill       E-stage issue, flush and trap kill
//   rs1_d..muldiv_d                D-stage operand/destination info
//   regwrite_w, rd_w               pipeline W-stage register write
//   unit_start/unit_is_div/unit_abort  datapath unit control
//   busy, stall_req, hold_req      status and hazard-unit requests
//   wb_en, wb_rd                   unit result writeback
module muldiv_scoreboard_ctrl
    import riscv_defines::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid_e,
    input  logic       issue_is_div_e,
    input  logic       issue_divzero_e,
    input  logic [4:0] issue_rd_e,
    input  logic       flush_e,
    input  logic       kill,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rd_d,
    input  logic       uses_rs1_d,
    input  logic       uses_rs2_d,
    input  logic       regwrite_d,
    input  logic       muldiv_d,
    input  logic       regwrite_w,
    input  logic [4:0] rd_w,
    output logic       unit_start,
    output logic       unit_is_div,
    output logic       unit_abort,
    output logic       busy,
    output logic       stall_req,
    output logic       hold_req,
    output logic       wb_en,
    output logic [4:0] wb_rd
);

    muldiv_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       prd;
    logic             pend;
    logic             is_div;
    logic             unused_is_div;

    logic             accept;
    logic             collision;
    logic [CNT_W-1:0] lat;
    muldiv_req_t      req;

    assign accept    = (state == IDLE) && issue_valid_e && !flush_e && !kill;
    assign collision = regwrite_w && (rd_w != 5'd0);
    assign lat       = issue_divzero_e ? CNT_W'(1)
                     : (issue_is_div_e ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT));

    assign unit_start  = accept;
    assign unit_is_div = accept && issue_is_div_e;
    assign unit_abort  = kill && (state != IDLE);
    assign busy        = (state != IDLE);
    assign hold_req    = (state == WB) && collision && !kill;
    assign wb_en       = (state == WB) && !collision && pend && !kill;
    assign wb_rd       = wb_en ? prd : 5'd0;

    // is_div is kept for debug visibility of the in-flight op type.
    assign unused_is_div = is_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            prd    <= 5'd0;
            pend   <= 1'b0;
            is_div <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prd    <= issue_rd_e;
                        pend   <= (issue_rd_e != 5'd0);
                        is_div <= issue_is_div_e;
                        if (lat == CNT_W'(1)) begin
                            state <= WB;
                        end else begin
                            state <= RUN;
                            cnt   <= lat - CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= WB;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WB: begin
                    // W is bubbled by the hazard unit on a hold, so the write lands next cycle.
                    if (!collision) begin
                        state <= IDLE;
                        pend  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req               = '0;
        req.issue_valid   = issue_valid_e;
        req.issue_is_div  = issue_is_div_e;
        req.issue_divzero = issue_divzero_e;
        req.issue_rd      = issue_rd_e;
        req.rs1           = rs1_d;
        req.rs2           = rs2_d;
        req.rd            = rd_d;
        req.uses_rs1      = uses_rs1_d;
        req.uses_rs2      = uses_rs2_d;
        req.regwrite      = regwrite_d;
        req.muldiv        = muldiv_d;
    end

    muldiv_dep_checker u_dep (
        .req       (req),
        .accept    (accept),
        .busy      (busy),
        .pend      (pend),
        .prd       (prd),
        .stall_req (stall_req)
    );

endmodule

// File: tb/tb_muldiv_scoreboard_ctrl.sv
// tb/tb_muldiv_scoreboard_ctrl.sv - directed self-checking bench for muldiv_scoreboard_ctrl
module tb_muldiv_scoreboard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid_e, issue_is_div_e, issue_divzero_e;
    logic [4:0] issue_rd_e;
    logic       flush_e, kill;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       uses_rs1_d, uses_rs2_d, regwrite_d, muldiv_d;
    logic       regwrite_w;
    logic [4:0] rd_w;
    logic       unit_start, unit_is_div, unit_abort, busy, stall_req, hold_req, wb_en;
    logic [4:0] wb_rd;

    int errors = 0;
    int checks = 0;
    int seen;

    always #5 clk = ~clk;

    muldiv_scoreboard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_e(issue_valid_e), .issue_is_div_e(issue_is_div_e),
        .issue_divzero_e(issue_divzero_e), .issue_rd_e(issue_rd_e),
        .flush_e(flush_e), .kill(kill),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
        .regwrite_d(regwrite_d), .muldiv_d(muldiv_d),
        .regwrite_w(regwrite_w), .rd_w(rd_w),
        .unit_start(unit_start), .unit_is_div(unit_is_div), .unit_abort(unit_abort),
        .busy(busy), .stall_req(stall_req), .hold_req(hold_req),
        .wb_en(wb_en), .wb_rd(wb_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven for that cycle.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, sampling on the falling edge.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_issue();
        issue_valid_e = 0; issue_is_div_e = 0; issue_divzero_e = 0; issue_rd_e = 0;
    endtask

    task automatic issue(input logic is_div, input logic dz, input logic [4:0] rd);
        issue_valid_e = 1; issue_is_div_e = is_div; issue_divzero_e = dz; issue_rd_e = rd;
    endtask

    initial begin
        rst_n = 0; clr_issue(); flush_e = 0; kill = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0; uses_rs1_d = 0; uses_rs2_d = 0;
        regwrite_d = 0; muldiv_d = 0; regwrite_w = 0; rd_w = 0;

        smp();
        chk("rst_outputs", {unit_start, unit_is_div, unit_abort, busy, stall_req, hold_req, wb_en, wb_rd}, 0);
        nxt(); rst_n = 1;

        // MUL rd=5
        nxt(); issue(0, 0, 5); smp();
        chk("mul_start", unit_start, 1);
        chk("mul_is_div", unit_is_div, 0);
        chk("mul_busy_t", busy, 0);
        nxt(); clr_issue(); smp();
        chk("mul_busy_t1", busy, 1);
        chk("mul_nowb_t1", wb_en, 0);
        nxt(); smp();
        chk("mul_nowb_t2", wb_en, 0);
        nxt(); smp();
        chk("mul_wb_t3", wb_en, 1);
        chk("mul_wbrd_t3", wb_rd, 5);
        chk("mul_busy_t3", busy, 1);
        nxt(); smp();
        chk("mul_idle_t4", busy, 0);
        chk("mul_nowb_t4", wb_en, 0);

        // DIV rd=7, divide by zero
        nxt(); issue(1, 1, 7); smp();
        chk("dz_start", unit_start, 1);
        chk("dz_is_div", unit_is_div, 1);
        nxt(); clr_issue(); smp();
        chk("dz_wb_t1", wb_en, 1);
        chk("dz_wbrd_t1", wb_rd, 7);
        nxt(); smp();
        chk("dz_idle_t2", busy, 0);

        // DIV rd=7, full latency
        nxt(); issue(1, 0, 7); smp();
        chk("div_start", unit_start, 1);
        seen = 0;
        for (int i = 1; i <= 32; i++) begin
            nxt(); clr_issue(); smp();
            if (wb_en) seen++;
        end
        chk("div_nowb_early", seen, 0);
        nxt(); smp();
        chk("div_wb_t33", wb_en, 1);
        chk("div_wbrd_t33", wb_rd, 7);
        nxt(); smp();
        chk("div_idle_t34", busy, 0);

        // W-stage collision in WB
        nxt(); issue(0, 0, 4); smp();
        nxt(); clr_issue(); smp();
        nxt(); smp();
        nxt(); regwrite_w = 1; rd_w = 9; smp();
        chk("col_hold", hold_req, 1);
        chk("col_nowb", wb_en, 0);
        nxt(); regwrite_w = 0; rd_w = 0; smp();
        chk("col_wb_next", wb_en, 1);
        chk("col_wbrd_next", wb_rd, 4);
        chk("col_hold_clear", hold_req, 0);
        nxt(); smp();
        chk("col_idle", busy, 0);

        // Write to x0 in W is not a collision
        nxt(); issue(1, 1, 6); smp();
        nxt(); clr_issue(); regwrite_w = 1; rd_w = 0; smp();
        chk("x0_nohold", hold_req, 0);
        chk("x0_wb", wb_en, 1);
        nxt(); regwrite_w = 0; smp();

        // RAW on rs2 against MUL rd=3
        uses_rs2_d = 1; rs2_d = 3;
        nxt(); issue(0, 0, 3); smp();
        chk("raw_stall_t", stall_req, 1);
        nxt(); clr_issue(); smp();
        chk("raw_stall_t1", stall_req, 1);
        nxt(); smp();
        chk("raw_stall_t2", stall_req, 1);
        nxt(); smp();
        chk("raw_stall_wb", stall_req, 1);
        chk("raw_wb", wb_en, 1);
        nxt(); smp();
        chk("raw_stall_drop", stall_req, 0);

        // rd=0 op: no RAW stall, never writes back
        uses_rs2_d = 1; rs2_d = 0;
        nxt(); issue(0, 0, 0); smp();
        chk("x0_raw_t", stall_req, 0);
        seen = 0;
        for (int i = 1; i <= 3; i++) begin
            nxt(); clr_issue(); smp();
            if (stall_req) seen++;
            if (wb_en) seen++;
        end
        chk("x0_no_stall_no_wb", seen, 0);
        nxt(); smp();
        chk("x0_idle", busy, 0);
        uses_rs2_d = 0;

        // WAW against in-flight rd=12
        regwrite_d = 1; rd_d = 12;
        nxt(); issue(0, 0, 12); smp();
        chk("waw_stall", stall_req, 1);
        nxt(); clr_issue(); rd_d = 13; smp();
        chk("waw_other_rd", stall_req, 0);
        regwrite_d = 0;
        nxt(); smp(); nxt(); smp(); nxt(); smp();
        chk("waw_idle", busy, 0);

        // Structural: second mul/div in D
        muldiv_d = 1;
        nxt(); issue(0, 0, 0); smp();
        chk("struct_accept", stall_req, 1);
        nxt(); clr_issue(); smp();
        chk("struct_busy", stall_req, 1);
        nxt(); smp(); nxt(); smp(); nxt(); smp();
        chk("struct_idle", stall_req, 0);
        muldiv_d = 0;

        // Flushed issue is ignored
        nxt(); issue(0, 0, 5); flush_e = 1; smp();
        chk("flush_nostart", unit_start, 0);
        nxt(); clr_issue(); flush_e = 0; smp();
        chk("flush_idle", busy, 0);

        // Kill in the accept cycle suppresses the issue without an abort
        nxt(); issue(0, 0, 5); kill = 1; smp();
        chk("kill_accept_nostart", unit_start, 0);
        chk("kill_accept_noabort", unit_abort, 0);
        nxt(); clr_issue(); kill = 0; smp();
        chk("kill_accept_idle", busy, 0);

        // Kill in RUN with cnt=10 (accept cycle + 23)
        nxt(); issue(1, 0, 8); smp();
        for (int i = 1; i <= 22; i++) begin
            nxt(); clr_issue(); smp();
        end
        nxt(); kill = 1; smp();
        chk("kill_abort", unit_abort, 1);
        chk("kill_nowb", wb_en, 0);
        nxt(); kill = 0; smp();
        chk("kill_idle", busy, 0);
        chk("kill_abort_pulse", unit_abort, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            nxt(); smp();
            if (wb_en || busy) seen++;
        end
        chk("kill_no_late_wb", seen, 0);

        // Reset mid-DIV
        uses_rs1_d = 1; rs1_d = 9;
        nxt(); issue(1, 0, 9); smp();
        for (int i = 1; i <= 5; i++) begin
            nxt(); clr_issue(); smp();
        end
        chk("rst_mid_stall_before", stall_req, 1);
        nxt(); rst_n = 0; #1;
        chk("rst_mid_outputs", {unit_start, unit_is_div, unit_abort, busy, stall_req, hold_req, wb_en, wb_rd}, 0);
        nxt(); rst_n = 1; smp();
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            nxt(); smp();
            if (wb_en || busy || stall_req) seen++;
        end
        chk("rst_mid_quiet", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // An issue while the controller is busy should be unreachable under the structural stall.
    always @(negedge clk) begin
        if (rst_n && busy && issue_valid_e && !flush_e) begin
            checks++;
            errors++;
            $error("FAIL issue_while_busy observed=1 expected=0");
        end
    end

endmodule
